seq_div: RTL

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_div.sv
// Sequential signed divider: unsigned restoring core plus a sign-fix cycle.
// Truncates toward zero like Verilog / and %, and flags a zero divisor.
module seq_div #(
  parameter int DIV_N_W = 8,
  parameter int DIV_D_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  input  logic [DIV_N_W-1:0] in_dividend_i,
  input  logic [DIV_D_W-1:0] in_divisor_i,
  output logic               out_valid_o,
  output logic [DIV_N_W-1:0] quot_o,
  output logic [DIV_D_W-1:0] rem_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(DIV_N_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [DIV_D_W:0]   prem;
  logic [DIV_N_W-1:0] qsr;
  logic [DIV_D_W-1:0] dabs;
  logic [DIV_D_W-1:0] dvd_lo;
  logic               sign_n;
  logic               sign_d;
  logic               dz;
  logic [CW-1:0]      cnt;

  logic [DIV_N_W-1:0] n_abs;
  logic [DIV_D_W-1:0] d_abs;
  logic [DIV_D_W:0]   shifted;
  logic [DIV_D_W+1:0] diff;
  logic [DIV_N_W-1:0] q_fix;
  logic [DIV_D_W-1:0] r_fix;

  // The magnitude of the most negative value still fits as an unsigned number.
  assign n_abs   = in_dividend_i[DIV_N_W-1] ? -in_dividend_i : in_dividend_i;
  assign d_abs   = in_divisor_i[DIV_D_W-1]  ? -in_divisor_i  : in_divisor_i;
  assign shifted = {prem[DIV_D_W-1:0], qsr[DIV_N_W-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dabs};
  assign q_fix   = (sign_n ^ sign_d) ? -qsr : qsr;
  assign r_fix   = sign_n ? -prem[DIV_D_W-1:0] : prem[DIV_D_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      prem          <= '0;
      qsr           <= '0;
      dabs          <= '0;
      dvd_lo        <= '0;
      sign_n        <= 1'b0;
      sign_d        <= 1'b0;
      dz            <= 1'b0;
      cnt           <= '0;
      out_valid_o   <= 1'b0;
      quot_o        <= '0;
      rem_o         <= '0;
      div_by_zero_o <= 1'b0;
    end else if (in_valid_i) begin
      // A new start always wins, aborting whatever was in flight.
      state       <= CALC;
      prem        <= '0;
      qsr         <= n_abs;
      dabs        <= d_abs;
      dvd_lo      <= in_dividend_i[DIV_D_W-1:0];
      sign_n      <= in_dividend_i[DIV_N_W-1];
      sign_d      <= in_divisor_i[DIV_D_W-1];
      dz          <= (in_divisor_i == '0);
      cnt         <= CW'(DIV_N_W);
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          if (cnt != '0) begin
            if (!diff[DIV_D_W+1]) begin
              prem <= diff[DIV_D_W:0];
              qsr  <= {qsr[DIV_N_W-2:0], 1'b1};
            end else begin
              prem <= shifted;
              qsr  <= {qsr[DIV_N_W-2:0], 1'b0};
            end
            cnt <= cnt - CW'(1);
          end else begin
            state <= FIX;
          end
        end
        FIX: begin
          // A zero divisor bypasses the core result with the defined constants.
          quot_o        <= dz ? '1 : q_fix;
          rem_o         <= dz ? dvd_lo : r_fix;
          div_by_zero_o <= dz;
          out_valid_o   <= 1'b1;
          state         <= DONE;
        end
        default: state <= state;
      endcase
    end
  end

endmodule
